// File: rtl/i2s_transmit.sv
// i2s_transmit: slave I2S transmitter on CLOCK_50; oversamples bclk/ws, buffers one in_left/in_right pair via in_valid/in_ready, drives sd MSB-first with frame_start/underrun pulses
module i2s_transmit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  ws,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  sd,
  output logic                  underrun,
  output logic                  frame_start
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PAD} state_t;
  state_t state, state_next;
  logic bclk_s1, bclk_s2, bclk_h, ws_s1, ws_s2, ws_cap, armed, pending, full;
  logic bclk_rise, bclk_fall, load;
  logic [DATA_WIDTH-1:0] buf_left, buf_right, frame_right, shreg, shreg_nx, word;
  logic [CW-1:0] bit_cnt;
  always_comb begin
    bclk_rise = bclk_s2 & ~bclk_h;
    bclk_fall = ~bclk_s2 & bclk_h;
    load = bclk_fall & pending & ((state != IDLE) | ~ws_cap);
    frame_start = load & ~ws_cap;
    underrun = frame_start & ~full;
    in_ready = ~full;
    word = ws_cap ? frame_right : full ? buf_left : '0;
    shreg_nx = shreg << 1;
    state_next = load ? LOAD : state == LOAD ? SHIFT :
                 (state == SHIFT && bclk_fall && bit_cnt == '0) ? PAD : state;
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      {bclk_s1, bclk_s2, bclk_h, ws_s1, ws_s2} <= '0;
      {ws_cap, armed, pending, full, sd} <= '0;
      buf_left <= '0;
      buf_right <= '0;
      frame_right <= '0;
      shreg <= '0;
      bit_cnt <= '0;
    end else begin
      {bclk_s1, bclk_s2, bclk_h} <= {bclk, bclk_s1, bclk_s2};
      {ws_s1, ws_s2} <= {ws, ws_s1};
      if (bclk_rise) begin
        ws_cap <= ws_s2;
        armed <= 1'b1;
      end
      if (bclk_rise && armed && ws_s2 != ws_cap) pending <= 1'b1;
      else if (bclk_fall) pending <= 1'b0;
      if (in_valid && !full) begin
        full <= 1'b1;
        buf_left <= in_left;
        buf_right <= in_right;
      end else if (frame_start) full <= 1'b0;
      if (frame_start) frame_right <= full ? buf_right : '0;
      if (load) begin
        shreg <= word;
        sd <= word[DATA_WIDTH-1];
        bit_cnt <= CW'(DATA_WIDTH - 1);
      end else if (state == SHIFT && bclk_fall) begin
        shreg <= shreg_nx;
        sd <= (bit_cnt != '0) & shreg_nx[DATA_WIDTH-1];
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_i2s_transmit.sv
// tb_i2s_transmit: directed I2S half-frames checked per BCLK slot against a receiver model, plus handshake/pulse monitor and literal word pins
`timescale 1ns/1ps
module tb_i2s_transmit;
  localparam int HP = 160;
  logic CLOCK_50 = 1'b0, reset = 1'b1, bclk = 1'b1, ws = 1'b0, in_valid = 1'b0;
  logic [15:0] in_left = '0, in_right = '0;
  logic in_ready, sd, underrun, frame_start;
  int checks = 0, fails = 0, fs_cnt = 0, ur_cnt = 0, acc_cnt = 0, slot_idx = 0;
  logic exp_sd = 1'b0, carry = 1'b0;
  logic got [0:63];
  logic [31:0] q [$];
  bit held = 1'b0, after_fs = 1'b0;

  i2s_transmit #(.DATA_WIDTH(16)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bclk(bclk), .ws(ws),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .sd(sd), .underrun(underrun), .frame_start(frame_start)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic slot_bit(input logic [15:0] w, input int k);
    return (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
  endfunction

  function automatic logic [15:0] rx_word(input int n);
    logic [15:0] r = '0;
    for (int i = 1; i <= n; i++) r = {r[14:0], got[i]};
    return r;
  endfunction

  always @(posedge bclk) begin
    got[slot_idx] = sd;
    chk($sformatf("sd_slot%0d", slot_idx), {31'd0, sd}, {31'd0, exp_sd});
  end

  always @(negedge CLOCK_50) begin
    if (frame_start) fs_cnt++;
    if (underrun) begin
      ur_cnt++;
      chk("underrun_with_fs", {31'd0, frame_start}, 32'd1);
    end
    if (reset) begin
      held = 1'b0;
      after_fs = 1'b0;
    end else begin
      if (held) chk("ready_low_while_full", {31'd0, in_ready}, 32'd0);
      if (after_fs) chk("ready_after_fs", {31'd0, in_ready}, 32'd1);
      after_fs = 1'b0;
      if (frame_start) begin
        chk("underrun_iff_empty", {31'd0, underrun}, {31'd0, in_ready});
        held = 1'b0;
        after_fs = !(in_valid && in_ready);
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        held = 1'b1;
      end
    end
  end

  initial begin
    bit hs;
    forever begin
      @(negedge CLOCK_50);
      hs = in_valid && in_ready && !reset;
      @(posedge CLOCK_50);
      #2;
      if (hs) void'(q.pop_front());
      if (q.size() > 0) begin
        in_valid = 1'b1;
        {in_left, in_right} = q[0];
      end else begin
        in_valid = 1'b0;
        {in_left, in_right} = $urandom;
      end
    end
  end

  task automatic idle_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      bclk = 1'b0;
      #HP;
      exp_sd = 1'b0;
      slot_idx = 0;
      bclk = 1'b1;
      #HP;
    end
  endtask

  task automatic half(input logic w, input int h, input logic [15:0] word, input int abort_at);
    for (int i = 0; i < h; i++) begin
      bclk = 1'b0;
      if (i == 0) ws = w;
      #HP;
      exp_sd = (i == 0) ? carry : slot_bit(word, i);
      slot_idx = i;
      bclk = 1'b1;
      if (i == abort_at) begin
        #1 reset = 1'b1;
        #1 chk("reset_sd_now", {31'd0, sd}, 32'd0);
        carry = 1'b0;
        #(HP - 2);
        return;
      end
      #HP;
    end
    carry = slot_bit(word, h);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    idle_clocks(6);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_fs", fs_cnt, 0);
    chk("reset_ur", ur_cnt, 0);
    chk("reset_sd", {31'd0, sd}, 32'd0);
    reset = 1'b0;
    q.push_back({16'hA5C3, 16'h3C5A});
    half(1'b1, 32, 16'h0000, -1);
    chk("idle_no_fs", fs_cnt, 0);
    half(1'b0, 32, 16'hA5C3, -1);
    chk("rx_left", {16'd0, rx_word(16)}, 32'h0000A5C3);
    half(1'b1, 32, 16'h3C5A, -1);
    chk("rx_right", {16'd0, rx_word(16)}, 32'h00003C5A);
    chk("single_fs", fs_cnt, 1);
    chk("single_ur", ur_cnt, 0);
    half(1'b0, 32, 16'h0000, -1);
    half(1'b1, 32, 16'h0000, -1);
    chk("underrun_fs", fs_cnt, 2);
    chk("underrun_cnt", ur_cnt, 1);
    for (int k = 1; k <= 8; k++) q.push_back({16'(k), 16'(16'h8000 | k)});
    for (int k = 1; k <= 8; k++) begin
      half(1'b0, 32, 16'(k), -1);
      half(1'b1, 32, 16'(16'h8000 | k), -1);
    end
    chk("b2b_rx_last_right", {16'd0, rx_word(16)}, 32'h00008008);
    chk("b2b_accepts", acc_cnt, 9);
    chk("b2b_fs", fs_cnt, 10);
    chk("b2b_ur", ur_cnt, 1);
    q.push_back({16'h1234, 16'h5678});
    half(1'b0, 32, 16'h1234, 7);
    idle_clocks(4);
    reset = 1'b0;
    chk("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    q.push_back({16'hBEEF, 16'h4321});
    half(1'b1, 32, 16'h0000, -1);
    half(1'b0, 32, 16'hBEEF, -1);
    chk("rx_after_reset_left", {16'd0, rx_word(16)}, 32'h0000BEEF);
    half(1'b1, 32, 16'h4321, -1);
    chk("rx_after_reset_right", {16'd0, rx_word(16)}, 32'h00004321);
    q.push_back({16'hCAFE, 16'h1357});
    q.push_back({16'h8421, 16'h7E81});
    half(1'b0, 12, 16'hCAFE, -1);
    chk("rx_short_left", {16'd0, rx_word(11)}, 32'h00000657);
    half(1'b1, 12, 16'h1357, -1);
    half(1'b0, 12, 16'h8421, -1);
    half(1'b1, 12, 16'h7E81, -1);
    half(1'b0, 32, 16'h0000, -1);
    half(1'b1, 32, 16'h0000, -1);
    chk("final_fs", fs_cnt, 15);
    chk("final_ur", ur_cnt, 2);
    chk("final_accepts", acc_cnt, 13);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
